// File: rtl/guided_play_checker.sv
// Guided-play scoring: prefetches each step's note from the song ROM,
// grades played keys as hit/miss and keeps per-song score tallies.
//
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   counter, song_address   current step/song from the step counter
//   key_played              most recently played key
//   rom_addr, rom_data      song ROM address out, note back (ROM_LATENCY later)
//   expected_note           note for the current step (valid when note_ready)
//   note_ready              expected_note is valid for the current step
//   hit, miss, song_done    one-cycle grading pulses
//   score, miss_count       saturating tallies for the current song
//   last_score              score of the most recently completed song
//   overrun                 sticky: an event arrived while a grade was pending
module guided_play_checker #(
    parameter int NUM_STEPS   = 9,
    parameter int ROM_LATENCY = 2,
    parameter int SCORE_W     = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [3:0]         counter,
    input  logic [1:0]         song_address,
    input  logic [2:0]         key_played,
    output logic [5:0]         rom_addr,
    input  logic [2:0]         rom_data,
    output logic [2:0]         expected_note,
    output logic               note_ready,
    output logic               hit,
    output logic               miss,
    output logic               song_done,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss_count,
    output logic [SCORE_W-1:0] last_score,
    output logic               overrun
);

    localparam logic [1:0] FETCH      = 2'd0;
    localparam logic [1:0] READY      = 2'd1;
    localparam logic [1:0] GRADE_PEND = 2'd2;

    localparam int WAIT_W = (ROM_LATENCY < 1) ? 1 : $clog2(ROM_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LATENCY);
    localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);
    localparam logic [SCORE_W-1:0] SAT = '1;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [5:0]        pos_prev;
    logic [5:0]        fetch_pos;
    logic [5:0]        pending_pos;
    logic [2:0]        pending_key;
    logic              pending;

    logic [5:0]         cur_pos;
    logic               evt;
    logic               do_grade;
    logic               grade_hit;
    logic               grade_last;
    logic               ovr_miss;
    logic               hit_inc;
    logic [1:0]         miss_inc;
    logic               done_now;
    logic [SCORE_W-1:0] score_nx;
    logic [SCORE_W-1:0] miss_nx;

    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] base,
        input logic [1:0]         inc
    );
        logic [SCORE_W:0] s;
        s = {1'b0, base} + (SCORE_W+1)'(inc);
        return s[SCORE_W] ? SAT : s[SCORE_W-1:0];
    endfunction

    assign cur_pos  = {song_address, counter};
    assign evt      = (cur_pos != pos_prev);
    assign rom_addr = 6'(fetch_pos[5:4]) * 6'(NUM_STEPS) + 6'(fetch_pos[3:0]);

    always_comb begin
        do_grade   = 1'b0;
        grade_hit  = 1'b0;
        grade_last = 1'b0;
        unique case (state)
            READY: begin
                if (evt) begin
                    do_grade   = 1'b1;
                    grade_hit  = (key_played == expected_note);
                    grade_last = (fetch_pos[3:0] == LAST_STEP);
                end
            end
            GRADE_PEND: begin
                do_grade   = 1'b1;
                grade_hit  = (pending_key == expected_note);
                grade_last = (pending_pos[3:0] == LAST_STEP);
            end
            default: ;
        endcase
        // A third event while one is still deferred cannot be graded.
        ovr_miss = evt && pending;
        hit_inc  = do_grade && grade_hit;
        miss_inc = {1'b0, do_grade && !grade_hit} + {1'b0, ovr_miss};
        done_now = do_grade && grade_last;
        // Tallies clear the cycle after song_done, before any new grade.
        score_nx = sat_add(song_done ? '0 : score, {1'b0, hit_inc});
        miss_nx  = sat_add(song_done ? '0 : miss_count, miss_inc);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= FETCH;
            wait_cnt      <= '0;
            pos_prev      <= '0;
            fetch_pos     <= '0;
            pending_pos   <= '0;
            pending_key   <= '0;
            pending       <= 1'b0;
            expected_note <= '0;
            note_ready    <= 1'b0;
            hit           <= 1'b0;
            miss          <= 1'b0;
            song_done     <= 1'b0;
            score         <= '0;
            miss_count    <= '0;
            last_score    <= '0;
            overrun       <= 1'b0;
        end else begin
            pos_prev   <= cur_pos;
            hit        <= hit_inc;
            miss       <= (miss_inc != 2'd0);
            song_done  <= done_now;
            score      <= score_nx;
            miss_count <= miss_nx;
            if (done_now) last_score <= score_nx;
            if (ovr_miss) overrun <= 1'b1;
            unique case (state)
                FETCH: begin
                    if (evt && !pending) begin
                        pending     <= 1'b1;
                        pending_key <= key_played;
                        pending_pos <= fetch_pos;
                    end
                    if (wait_cnt == WAIT_LAST) begin
                        expected_note <= rom_data;
                        note_ready    <= 1'b1;
                        state <= (pending || evt) ? GRADE_PEND : READY;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (evt) begin
                        state      <= FETCH;
                        fetch_pos  <= cur_pos;
                        wait_cnt   <= '0;
                        note_ready <= 1'b0;
                    end
                end
                GRADE_PEND: begin
                    pending    <= 1'b0;
                    state      <= FETCH;
                    fetch_pos  <= cur_pos;
                    wait_cnt   <= '0;
                    note_ready <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_guided_play_checker.sv
// Self-checking bench for guided_play_checker: ROM model, grading
// scoreboard, and per-scenario tasks.
module tb_guided_play_checker;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [3:0] counter;
    logic [1:0] song_address;
    logic [2:0] key_played;
    logic [5:0] rom_addr;
    logic [2:0] rom_data;
    logic [2:0] expected_note;
    logic       note_ready;
    logic       hit;
    logic       miss;
    logic       song_done;
    logic [7:0] score;
    logic [7:0] miss_count;
    logic [7:0] last_score;
    logic       overrun;

    guided_play_checker dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .counter       (counter),
        .song_address  (song_address),
        .key_played    (key_played),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .expected_note (expected_note),
        .note_ready    (note_ready),
        .hit           (hit),
        .miss          (miss),
        .song_done     (song_done),
        .score         (score),
        .miss_count    (miss_count),
        .last_score    (last_score),
        .overrun       (overrun)
    );

    always #5 clk_in = ~clk_in;

    logic [2:0] rom [64];
    logic [2:0] rom_q1;

    // Two-cycle BRAM with output register.
    always @(posedge clk_in) begin
        rom_q1   <= rom[rom_addr];
        rom_data <= rom_q1;
    end

    typedef struct packed {
        logic       h;
        logic       m;
        logic       d;
        logic [7:0] sc;
        logic [7:0] mc;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   m_score = 0;
    int   m_miss  = 0;
    int   cur_song = 0;
    int   cur_step = 0;

    // Pulse monitor: every grading pulse must match the next expectation.
    always @(posedge clk_in) begin
        #1;
        if (hit || miss || song_done) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got h=%0b m=%0b d=%0b, none expected",
                         hit, miss, song_done);
            end else begin
                e = sb.pop_front();
                if ({hit, miss, song_done, score, miss_count} !==
                    {e.h, e.m, e.d, e.sc, e.mc})
                    $display("FAIL sb_grade: got h%0b m%0b d%0b sc%0d mc%0d, want h%0b m%0b d%0b sc%0d mc%0d",
                             hit, miss, song_done, score, miss_count,
                             e.h, e.m, e.d, e.sc, e.mc);
                else
                    passed++;
            end
        end
    end

    task automatic expect_grade(input int sg, input int st, input logic [2:0] key);
        exp_t e;
        logic [2:0] note;
        note = rom[sg * 9 + st];
        e.h = (key == note);
        e.m = !e.h;
        e.d = (st == 8);
        if (e.h) m_score++;
        else m_miss++;
        e.sc = 8'(m_score);
        e.mc = 8'(m_miss);
        sb.push_back(e);
        if (e.d) begin
            m_score = 0;
            m_miss  = 0;
        end
    endtask

    task automatic expect_overrun();
        exp_t e;
        m_miss++;
        e.h  = 1'b0;
        e.m  = 1'b1;
        e.d  = 1'b0;
        e.sc = 8'(m_score);
        e.mc = 8'(m_miss);
        sb.push_back(e);
    endtask

    task automatic step_to(input int sg, input int st, input logic [2:0] key,
                           input bit push);
        if (push) expect_grade(cur_song, cur_step, key);
        @(negedge clk_in);
        song_address = 2'(sg);
        counter      = 4'(st);
        key_played   = key;
        cur_song     = sg;
        cur_step     = st;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk_in);
        while (!note_ready && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        total++;
        if (!note_ready)
            $display("FAIL ready_timeout: note_ready=%0b after %0d cycles, want 1",
                     note_ready, n);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst_n_in     = 1'b0;
        counter      = 4'd0;
        song_address = 2'd0;
        key_played   = 3'd0;
        repeat (2) @(negedge clk_in);
        total++;
        if ({note_ready, hit, miss, song_done, overrun, score, miss_count,
             last_score, expected_note, rom_addr} !== '0)
            $display("FAIL reset_outputs: got nr%0b sc%0d mc%0d ls%0d en%0d ra%0d, want all 0",
                     note_ready, score, miss_count, last_score, expected_note, rom_addr);
        else passed++;
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        total++;
        if (note_ready !== 1'b0)
            $display("FAIL reset_early_ready: got %0b want 0", note_ready);
        else passed++;
        @(posedge clk_in);
        #1;
        total++;
        if (note_ready !== 1'b1 || expected_note !== 3'd3)
            $display("FAIL reset_first_note: got nr%0b en%0d want nr1 en3",
                     note_ready, expected_note);
        else passed++;
    endtask

    task automatic test_hit();
        step_to(0, 1, 3'd3, 1);
        @(negedge clk_in);
        total++;
        if (sb.size() != 0)
            $display("FAIL hit_latency: pending expectations %0d want 0", sb.size());
        else passed++;
        wait_ready();
        total++;
        if (expected_note !== 3'd1 || rom_addr !== 6'd1)
            $display("FAIL hit_next_note: got en%0d ra%0d want en1 ra1",
                     expected_note, rom_addr);
        else passed++;
    endtask

    task automatic test_miss();
        step_to(0, 2, 3'd5, 1);
        wait_ready();
        total++;
        if (score !== 8'd1 || miss_count !== 8'd1)
            $display("FAIL miss_tally: got sc%0d mc%0d want sc1 mc1",
                     score, miss_count);
        else passed++;
    endtask

    task automatic test_song_end();
        logic [2:0] keys [7];
        keys = '{3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd0, 3'd7};
        for (int i = 0; i < 7; i++) begin
            if (i == 6) step_to(1, 0, keys[i], 1);
            else step_to(0, i + 3, keys[i], 1);
            wait_ready();
        end
        total++;
        if (last_score !== 8'd7 || score !== 8'd0 || miss_count !== 8'd0)
            $display("FAIL song_end_tally: got ls%0d sc%0d mc%0d want ls7 sc0 mc0",
                     last_score, score, miss_count);
        else passed++;
        total++;
        if (rom_addr !== 6'd9 || expected_note !== rom[9])
            $display("FAIL song_end_addr: got ra%0d en%0d want ra9 en%0d",
                     rom_addr, expected_note, rom[9]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        step_to(1, 1, rom[9], 1);
        step_to(1, 2, rom[10], 1);
        repeat (12) @(negedge clk_in);
        total++;
        if (sb.size() != 0 || overrun !== 1'b0 || rom_addr !== 6'd11)
            $display("FAIL b2b_two: got left%0d ov%0b ra%0d want left0 ov0 ra11",
                     sb.size(), overrun, rom_addr);
        else passed++;
        step_to(1, 3, rom[11], 1);
        step_to(1, 4, rom[12], 0);
        expect_overrun();
        expect_grade(1, 3, rom[12]);
        step_to(1, 5, 3'd0, 0);
        repeat (12) @(negedge clk_in);
        total++;
        if (sb.size() != 0 || overrun !== 1'b1)
            $display("FAIL b2b_three: got left%0d ov%0b want left0 ov1",
                     sb.size(), overrun);
        else passed++;
        total++;
        if (note_ready !== 1'b1 || rom_addr !== 6'd14 || expected_note !== rom[14])
            $display("FAIL b2b_refetch: got nr%0b ra%0d en%0d want nr1 ra14 en%0d",
                     note_ready, rom_addr, expected_note, rom[14]);
        else passed++;
        total++;
        if (score !== 8'(m_score) || miss_count !== 8'(m_miss))
            $display("FAIL b2b_tally: got sc%0d mc%0d want sc%0d mc%0d",
                     score, miss_count, m_score, m_miss);
        else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        step_to(1, 6, rom[14], 1);
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        total++;
        if ({note_ready, hit, miss, song_done, overrun, score, miss_count,
             last_score, rom_addr} !== '0)
            $display("FAIL mid_reset_outputs: got nr%0b ov%0b sc%0d mc%0d ls%0d ra%0d, want all 0",
                     note_ready, overrun, score, miss_count, last_score, rom_addr);
        else passed++;
        m_score      = 0;
        m_miss       = 0;
        song_address = 2'd0;
        counter      = 4'd0;
        key_played   = 3'd0;
        cur_song     = 0;
        cur_step     = 0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        total++;
        if (note_ready !== 1'b1 || expected_note !== 3'd3 || rom_addr !== 6'd0)
            $display("FAIL mid_reset_refetch: got nr%0b en%0d ra%0d want nr1 en3 ra0",
                     note_ready, expected_note, rom_addr);
        else passed++;
    endtask

    task automatic test_repress();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            key_played = 3'(i + 1);
            if (hit || miss || song_done) pulses++;
        end
        repeat (2) @(negedge clk_in);
        if (hit || miss || song_done) pulses++;
        total++;
        if (pulses != 0 || score !== 8'd0 || note_ready !== 1'b1)
            $display("FAIL repress_no_grade: got pulses%0d sc%0d nr%0b want 0 0 1",
                     pulses, score, note_ready);
        else passed++;
    endtask

    initial begin
        logic [2:0] song0 [9];
        song0 = '{3'd3, 3'd1, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd2, 3'd7};
        for (int i = 0; i < 64; i++) rom[i] = 3'((i * 5 + 2) % 8);
        for (int i = 0; i < 9; i++) rom[i] = song0[i];

        test_reset();
        test_hit();
        test_miss();
        test_song_end();
        test_back_to_back();
        test_reset_mid_fetch();
        test_repress();

        repeat (2) @(negedge clk_in);
        total++;
        if (sb.size() != 0)
            $display("FAIL sb_leftover: got %0d expectations unmet, want 0", sb.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
